// File: rtl/reg_writeback_queue_pkg.sv
// Shared widths and the write-back entry type used by the register write-back queue.
package reg_writeback_queue_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ADDR_W   = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]   rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/reg_writeback_queue_wb_fifo.sv
// Generic DEPTH-entry FIFO with occupancy and all-slot visibility for bypass scans.
module wb_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 37,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              din,
    output logic [W-1:0]              head,
    output logic [DEPTH-1:0][W-1:0]   slots,
    output logic [PTR_W-1:0]          rd_ptr,
    output logic [CNT_W-1:0]          count,
    output logic                      empty,
    output logic                      full
);
    logic [DEPTH-1:0][W-1:0] mem;
    logic [PTR_W-1:0]        wr_ptr;
    logic                    do_pop;
    logic                    do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // When full, a push is legal only because the popped slot frees on the same edge.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign slots = mem;
endmodule

// File: rtl/reg_writeback_queue.sv
// Arbitrates ALU/LSU results into a write-back FIFO, drains it to reg_file, and bypasses queued data to decode.
module reg_writeback_queue
    import reg_writeback_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int XLEN  = XLEN_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]       i_alu_data,
    input  logic                  i_lsu_valid,
    output logic                  o_lsu_ready,
    input  logic [REG_ADDR_W-1:0] i_lsu_rd,
    input  logic [XLEN-1:0]       i_lsu_data,
    input  logic                  i_wr_stall,
    output logic                  o_wr,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [XLEN-1:0]       o_write_data,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output logic                  o_fwd1_hit,
    output logic [XLEN-1:0]       o_fwd1_data,
    output logic                  o_fwd2_hit,
    output logic [XLEN-1:0]       o_fwd2_data,
    output logic                  o_empty,
    output logic [CNT_W-1:0]      o_count
);
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } entry_t;

    localparam int EW = REG_ADDR_W + XLEN;

    logic [EW-1:0]            head;
    logic [DEPTH-1:0][EW-1:0] slots;
    logic [PTR_W-1:0]         rd_ptr;
    logic                     full;
    logic                     deq;
    logic                     space;
    logic                     accept;
    logic                     push;
    entry_t                   sel;
    entry_t                   head_e;
    entry_t                   scan_e;
    logic [PTR_W-1:0]         scan_idx;

    assign deq         = ~o_empty & ~i_wr_stall;
    assign space       = ~full | deq;
    assign o_lsu_ready = space;
    assign o_alu_ready = space & ~i_lsu_valid;
    assign accept      = (i_lsu_valid & o_lsu_ready) | (i_alu_valid & o_alu_ready);

    assign sel.rd   = i_lsu_valid ? i_lsu_rd   : i_alu_rd;
    assign sel.data = i_lsu_valid ? i_lsu_data : i_alu_data;
    // Writes to x0 complete the handshake but are dropped rather than queued.
    assign push     = accept & (sel.rd != '0);

    wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (deq),
        .din    (sel),
        .head   (head),
        .slots  (slots),
        .rd_ptr (rd_ptr),
        .count  (o_count),
        .empty  (o_empty),
        .full   (full)
    );

    assign head_e       = entry_t'(head);
    assign o_wr         = deq;
    assign o_rd         = head_e.rd;
    assign o_write_data = head_e.data;

    // Scan oldest to youngest so the last match (the youngest) wins.
    always_comb begin
        o_fwd1_hit  = 1'b0;
        o_fwd1_data = '0;
        o_fwd2_hit  = 1'b0;
        o_fwd2_data = '0;
        scan_idx    = '0;
        scan_e      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr + PTR_W'(k);
            scan_e   = entry_t'(slots[scan_idx]);
            if (CNT_W'(k) < o_count) begin
                if (i_rs1 != '0 && scan_e.rd == i_rs1) begin
                    o_fwd1_hit  = 1'b1;
                    o_fwd1_data = scan_e.data;
                end
                if (i_rs2 != '0 && scan_e.rd == i_rs2) begin
                    o_fwd2_hit  = 1'b1;
                    o_fwd2_data = scan_e.data;
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue with a write-port scoreboard and a reg_file model.
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_alu_valid, o_alu_ready;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        i_lsu_valid, o_lsu_ready;
    logic [4:0]  i_lsu_rd;
    logic [31:0] i_lsu_data;
    logic        i_wr_stall;
    logic        o_wr;
    logic [4:0]  o_rd;
    logic [31:0] o_write_data;
    logic [4:0]  i_rs1, i_rs2;
    logic        o_fwd1_hit, o_fwd2_hit;
    logic [31:0] o_fwd1_data, o_fwd2_data;
    logic        o_empty;
    logic [2:0]  o_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [36:0] exp_q[$];
    logic [31:0] rf[32];

    always #5 clk = ~clk;

    reg_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
        .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
        .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready),
        .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data),
        .i_wr_stall(i_wr_stall),
        .o_wr(o_wr), .o_rd(o_rd), .o_write_data(o_write_data),
        .i_rs1(i_rs1), .i_rs2(i_rs2),
        .o_fwd1_hit(o_fwd1_hit), .o_fwd1_data(o_fwd1_data),
        .o_fwd2_hit(o_fwd2_hit), .o_fwd2_data(o_fwd2_data),
        .o_empty(o_empty), .o_count(o_count)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_check();
        @(negedge clk);
    endtask

    task automatic wait_empty(input string name, input int max_cycles);
        int n = 0;
        while (!o_empty && n < max_cycles) begin
            to_check();
            n++;
        end
        chk(name, {63'd0, o_empty}, 64'd1);
    endtask

    // Monitor: every committed write must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && o_wr) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", {63'd0, o_wr}, 64'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("wr_rd", {59'd0, o_rd}, {59'd0, e[36:32]});
                chk("wr_data", {32'd0, o_write_data}, {32'd0, e[31:0]});
            end
            rf[o_rd] = o_write_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = '0;
        rst_n = 1'b0;
        i_alu_valid = 0; i_alu_rd = '0; i_alu_data = '0;
        i_lsu_valid = 0; i_lsu_rd = '0; i_lsu_data = '0;
        i_wr_stall = 0; i_rs1 = 5'd5; i_rs2 = 5'd7;

        // Reset state
        to_check();
        chk("rst_empty", {63'd0, o_empty}, 64'd1);
        chk("rst_count", {61'd0, o_count}, 64'd0);
        chk("rst_wr", {63'd0, o_wr}, 64'd0);
        chk("rst_fwd1", {63'd0, o_fwd1_hit}, 64'd0);
        chk("rst_fwd2", {63'd0, o_fwd2_hit}, 64'd0);
        to_drive();
        rst_n = 1'b1; i_rs1 = '0; i_rs2 = '0;

        // 1: single ALU result, one-cycle latency to the write port
        to_drive();
        i_alu_valid = 1; i_alu_rd = 5'd5; i_alu_data = 32'hDEADBEEF;
        to_check();
        chk("t1_ready", {63'd0, o_alu_ready}, 64'd1);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        to_drive();
        i_alu_valid = 0;
        to_check();
        chk("t1_wr", {63'd0, o_wr}, 64'd1);
        chk("t1_count", {61'd0, o_count}, 64'd1);
        to_drive();
        to_check();
        chk("t1_empty", {63'd0, o_empty}, 64'd1);
        chk("t1_x5", {32'd0, rf[5]}, 64'hDEADBEEF);

        // 2: LSU beats ALU; ALU goes next cycle
        to_drive();
        i_lsu_valid = 1; i_lsu_rd = 5'd3; i_lsu_data = 32'h11;
        i_alu_valid = 1; i_alu_rd = 5'd4; i_alu_data = 32'h22;
        to_check();
        chk("t2_lsu_ready", {63'd0, o_lsu_ready}, 64'd1);
        chk("t2_alu_ready", {63'd0, o_alu_ready}, 64'd0);
        exp_q.push_back({5'd3, 32'h11});
        to_drive();
        i_lsu_valid = 0;
        to_check();
        chk("t2_alu_ready2", {63'd0, o_alu_ready}, 64'd1);
        exp_q.push_back({5'd4, 32'h22});
        to_drive();
        i_alu_valid = 0;
        wait_empty("t2_drain", 20);
        chk("t2_x3", {32'd0, rf[3]}, 64'h11);
        chk("t2_x4", {32'd0, rf[4]}, 64'h22);

        // 3: stall fills the queue; release lets the 5th in alongside the first dequeue
        to_drive();
        i_wr_stall = 1;
        for (int i = 0; i < 4; i++) begin
            i_alu_valid = 1; i_alu_rd = 5'(8 + i); i_alu_data = 32'h100 + 32'(i);
            to_check();
            chk("t3_ready_fill", {63'd0, o_alu_ready}, 64'd1);
            exp_q.push_back({5'(8 + i), 32'h100 + 32'(i)});
            to_drive();
        end
        i_alu_rd = 5'd12; i_alu_data = 32'h104;
        to_check();
        chk("t3_count_full", {61'd0, o_count}, 64'd4);
        chk("t3_alu_ready_full", {63'd0, o_alu_ready}, 64'd0);
        chk("t3_lsu_ready_full", {63'd0, o_lsu_ready}, 64'd0);
        chk("t3_wr_stalled", {63'd0, o_wr}, 64'd0);
        to_drive();
        i_wr_stall = 0;
        to_check();
        chk("t3_ready_release", {63'd0, o_alu_ready}, 64'd1);
        chk("t3_wr_release", {63'd0, o_wr}, 64'd1);
        exp_q.push_back({5'd12, 32'h104});
        to_drive();
        i_alu_valid = 0;
        to_check();
        chk("t3_count_enq_deq", {61'd0, o_count}, 64'd4);
        wait_empty("t3_drain", 20);

        // 4: bypass picks the youngest of two writes to x7
        to_drive();
        i_wr_stall = 1;
        i_alu_valid = 1; i_alu_rd = 5'd7; i_alu_data = 32'h1;
        to_check();
        chk("t4_ready_a", {63'd0, o_alu_ready}, 64'd1);
        exp_q.push_back({5'd7, 32'h1});
        to_drive();
        i_alu_data = 32'h2;
        to_check();
        chk("t4_ready_b", {63'd0, o_alu_ready}, 64'd1);
        exp_q.push_back({5'd7, 32'h2});
        to_drive();
        i_alu_valid = 0; i_rs1 = 5'd7; i_rs2 = 5'd0;
        to_check();
        chk("t4_fwd1_hit", {63'd0, o_fwd1_hit}, 64'd1);
        chk("t4_fwd1_data", {32'd0, o_fwd1_data}, 64'h2);
        chk("t4_fwd2_rs0", {63'd0, o_fwd2_hit}, 64'd0);
        to_drive();
        i_rs1 = 5'd9; i_rs2 = 5'd7;
        to_check();
        chk("t4_fwd1_miss", {63'd0, o_fwd1_hit}, 64'd0);
        chk("t4_fwd2_hit", {63'd0, o_fwd2_hit}, 64'd1);
        chk("t4_fwd2_data", {32'd0, o_fwd2_data}, 64'h2);
        to_drive();
        i_wr_stall = 0; i_rs1 = 5'd7; i_rs2 = 5'd0;
        to_check();
        chk("t4_fwd_while_drain", {32'd0, o_fwd1_data}, 64'h2);
        to_drive();
        to_check();
        chk("t4_fwd_head_hit", {63'd0, o_fwd1_hit}, 64'd1);
        chk("t4_fwd_head_data", {32'd0, o_fwd1_data}, 64'h2);
        wait_empty("t4_drain", 20);
        chk("t4_x7", {32'd0, rf[7]}, 64'h2);
        i_rs1 = '0;

        // 5: write to x0 is accepted but never stored
        to_drive();
        i_alu_valid = 1; i_alu_rd = 5'd0; i_alu_data = 32'hFFFF;
        to_check();
        chk("t5_ready", {63'd0, o_alu_ready}, 64'd1);
        to_drive();
        i_alu_valid = 0;
        to_check();
        chk("t5_count", {61'd0, o_count}, 64'd0);
        chk("t5_empty", {63'd0, o_empty}, 64'd1);
        chk("t5_wr", {63'd0, o_wr}, 64'd0);

        // 6: async reset mid-drain discards queued entries
        to_drive();
        i_wr_stall = 1;
        for (int i = 0; i < 3; i++) begin
            i_alu_valid = 1; i_alu_rd = 5'(20 + i); i_alu_data = 32'h600 + 32'(i);
            to_drive();
        end
        i_alu_valid = 0;
        to_check();
        chk("t6_count3", {61'd0, o_count}, 64'd3);
        to_drive();
        i_wr_stall = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr", {63'd0, o_wr}, 64'd0);
        chk("t6_rst_count", {61'd0, o_count}, 64'd0);
        to_drive();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            to_check();
            chk("t6_no_wr", {63'd0, o_wr}, 64'd0);
        end
        chk("t6_x20_untouched", {32'd0, rf[20]}, 64'd0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
